// File: rtl/or2_vector_checker_pkg.sv
// Shared definitions for the OR2 vector checker: FSM encoding, defaults, settle helper.
// Enable first-fail capture with: `define OR2_VECTOR_CHECKER_FIRST_FAIL_EN
package or2_vector_checker_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int DEFAULT_SETTLE_CYCLES = 1;
   localparam int DEFAULT_CNT_WIDTH     = 32;

   // A settle interval of zero still needs one cycle for the OR stage to respond.
   function automatic int eff_settle(input int cycles);
      return (cycles < 1) ? 1 : cycles;
   endfunction

   function automatic int settle_cnt_width(input int cycles);
      return (eff_settle(cycles) > 1) ? $clog2(eff_settle(cycles)) : 1;
   endfunction

endpackage

// File: rtl/or2_vector_checker_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != {WIDTH{1'b1}})) begin
         count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/or2_vector_checker.sv
// Drives {a,b} vectors into a 2-input OR stage, samples y after a settle interval and scores it.
// Optional first-fail capture ports are built when OR2_VECTOR_CHECKER_FIRST_FAIL_EN is defined.
module or2_vector_checker
   import or2_vector_checker_pkg::*;
#(
   parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
   parameter int CNT_WIDTH     = DEFAULT_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 vec_valid,
   output logic                 vec_ready,
   input  logic                 vec_a,
   input  logic                 vec_b,
   input  logic                 vec_yexp,
   input  logic                 vec_eof,
   output logic                 a,
   output logic                 b,
   input  logic                 y,
   output logic                 chk_pulse,
   output logic                 err_pulse,
   output logic [CNT_WIDTH-1:0] vector_count,
   output logic [CNT_WIDTH-1:0] error_count,
   output logic                 finished,
   output logic                 pass
`ifdef OR2_VECTOR_CHECKER_FIRST_FAIL_EN
   ,
   output logic                 first_fail_valid,
   output logic [CNT_WIDTH-1:0] first_fail_index,
   output logic                 first_fail_a,
   output logic                 first_fail_b,
   output logic                 first_fail_y
`endif
);

   localparam int SETTLE_EFF = eff_settle(SETTLE_CYCLES);
   localparam int SCW        = settle_cnt_width(SETTLE_CYCLES);

   state_t         state;
   logic           yexp_r;
   logic [SCW-1:0] settle_cnt;
   logic           mismatch;
   logic           vec_inc;
   logic           err_inc;

   // X/Z on y scores as a mismatch in simulation; hardware sees plain inequality.
   assign mismatch = (y !== yexp_r);
   assign vec_inc  = (state == CHECK);
   assign err_inc  = (state == CHECK) && mismatch;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a          <= 1'b0;
         b          <= 1'b0;
         yexp_r     <= 1'b0;
         settle_cnt <= '0;
         vec_ready  <= 1'b0;
         chk_pulse  <= 1'b0;
         err_pulse  <= 1'b0;
         finished   <= 1'b0;
         pass       <= 1'b0;
      end else begin
         chk_pulse <= 1'b0;
         err_pulse <= 1'b0;
         case (state)
            IDLE: begin
               // vec_ready comes up one clock out of reset; nothing is taken before that.
               if (!vec_ready) begin
                  vec_ready <= 1'b1;
               end else if (vec_valid) begin
                  a          <= vec_a;
                  b          <= vec_b;
                  yexp_r     <= vec_yexp;
                  settle_cnt <= SCW'(SETTLE_EFF - 1);
                  vec_ready  <= 1'b0;
                  state      <= SETTLE;
               end else if (vec_eof) begin
                  vec_ready <= 1'b0;
                  finished  <= 1'b1;
                  pass      <= (error_count == '0);
                  state     <= DONE;
               end
            end
            SETTLE: begin
               if (settle_cnt == '0) begin
                  state <= CHECK;
               end else begin
                  settle_cnt <= settle_cnt - SCW'(1);
               end
            end
            CHECK: begin
               chk_pulse <= 1'b1;
               err_pulse <= mismatch;
               vec_ready <= 1'b1;
               state     <= IDLE;
            end
            DONE: begin
               finished  <= 1'b1;
               pass      <= (error_count == '0);
               vec_ready <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_vector_count (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (vec_inc),
      .count (vector_count)
   );

   sat_counter #(.WIDTH(CNT_WIDTH)) u_error_count (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (err_inc),
      .count (error_count)
   );

`ifdef OR2_VECTOR_CHECKER_FIRST_FAIL_EN
   // Index is the pre-increment vector_count, i.e. the 0-based position of the failing vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_fail_valid <= 1'b0;
         first_fail_index <= '0;
         first_fail_a     <= 1'b0;
         first_fail_b     <= 1'b0;
         first_fail_y     <= 1'b0;
      end else if (err_inc && !first_fail_valid) begin
         first_fail_valid <= 1'b1;
         first_fail_index <= vector_count;
         first_fail_a     <= a;
         first_fail_b     <= b;
         first_fail_y     <= y;
      end
   end
`endif

endmodule

// File: tb/tb_or2_vector_checker.sv
// Scoreboard bench for or2_vector_checker: three instances (settle 1/32-bit, settle 3/32-bit, settle 1/2-bit).
module tb_or2_vector_checker;

   localparam int NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [NI-1:0] rst_n, vec_valid, vec_ready, vec_a, vec_b, vec_yexp, vec_eof;
   logic [NI-1:0] a_o, b_o, y_i, chk, err, fin, pas;
   logic [31:0]   vcnt [NI];
   logic [31:0]   ecnt [NI];
`ifdef OR2_VECTOR_CHECKER_FIRST_FAIL_EN
   logic [NI-1:0] ff_v, ff_a, ff_b, ff_y;
   logic [31:0]   ff_idx [NI];
`endif

   // Behavioural OR stage in the loop of every instance.
   assign y_i = a_o | b_o;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_q [NI][$];
   int acc_q [NI][$];
   int chk_seen [NI];

   function automatic int s_of(input int i);
      return (i == 1) ? 3 : 1;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int S = (g == 1) ? 3 : 1;
      localparam int W = (g == 2) ? 2 : 32;
      logic [W-1:0] vc, ec;
`ifdef OR2_VECTOR_CHECKER_FIRST_FAIL_EN
      logic [W-1:0] fi;
`endif
      or2_vector_checker #(.SETTLE_CYCLES(S), .CNT_WIDTH(W)) u_dut (
         .clk          (clk),
         .rst_n        (rst_n[g]),
         .vec_valid    (vec_valid[g]),
         .vec_ready    (vec_ready[g]),
         .vec_a        (vec_a[g]),
         .vec_b        (vec_b[g]),
         .vec_yexp     (vec_yexp[g]),
         .vec_eof      (vec_eof[g]),
         .a            (a_o[g]),
         .b            (b_o[g]),
         .y            (y_i[g]),
         .chk_pulse    (chk[g]),
         .err_pulse    (err[g]),
         .vector_count (vc),
         .error_count  (ec),
         .finished     (fin[g]),
         .pass         (pas[g])
`ifdef OR2_VECTOR_CHECKER_FIRST_FAIL_EN
         ,
         .first_fail_valid (ff_v[g]),
         .first_fail_index (fi),
         .first_fail_a     (ff_a[g]),
         .first_fail_b     (ff_b[g]),
         .first_fail_y     (ff_y[g])
`endif
      );
      assign vcnt[g] = 32'(vc);
      assign ecnt[g] = 32'(ec);
`ifdef OR2_VECTOR_CHECKER_FIRST_FAIL_EN
      assign ff_idx[g] = 32'(fi);
`endif
   end

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every chk_pulse.
   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (rst_n[i] && chk[i] === 1'b1) begin
            chk_seen[i]++;
            if (exp_q[i].size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_chk inst%0d: got chk_pulse, expected none", i);
            end else begin
               check($sformatf("err_pulse inst%0d", i), longint'(err[i]), longint'(exp_q[i].pop_front()));
               check($sformatf("latency inst%0d", i), longint'(cyc - acc_q[i].pop_front()), longint'(s_of(i) + 1));
            end
         end else if (rst_n[i] && err[i] === 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stray_err inst%0d: got err_pulse without chk_pulse, expected 0", i);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input int i, input bit va, input bit vb, input bit vy,
                       input bit eerr, input bit hold, output int acc);
      int t;
      vec_a[i] = va; vec_b[i] = vb; vec_yexp[i] = vy; vec_valid[i] = 1'b1;
      t = 0;
      while (!vec_ready[i] && t < 50) begin
         @(negedge clk);
         t++;
      end
      acc = -1;
      if (!vec_ready[i]) begin
         check($sformatf("accept_timeout inst%0d", i), 0, 1);
         vec_valid[i] = 1'b0;
         return;
      end
      acc = cyc + 1;
      exp_q[i].push_back(int'(eerr));
      acc_q[i].push_back(acc);
      @(negedge clk);
      if (!hold) vec_valid[i] = 1'b0;
   endtask

   task automatic wait_fin(input int i);
      for (int t = 0; t < 100 && !fin[i]; t++) @(negedge clk);
      check($sformatf("finished inst%0d", i), longint'(fin[i]), 1);
   endtask

   task automatic do_reset(input int i);
      vec_valid[i] = 1'b0;
      vec_eof[i]   = 1'b0;
      rst_n[i]     = 1'b0;
      @(negedge clk);
      chk_seen[i] = 0;
      rst_n[i]    = 1'b1;
      @(negedge clk);
      check($sformatf("ready_after_reset inst%0d", i), longint'(vec_ready[i]), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int prev;
      rst_n = '0; vec_valid = '0; vec_a = '0; vec_b = '0; vec_yexp = '0; vec_eof = '0;
      for (int i = 0; i < NI; i++) chk_seen[i] = 0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("rst vec_ready inst%0d", i), longint'(vec_ready[i]), 0);
         check($sformatf("rst a inst%0d", i), longint'(a_o[i]), 0);
         check($sformatf("rst chk inst%0d", i), longint'(chk[i]), 0);
         check($sformatf("rst vector_count inst%0d", i), longint'(vcnt[i]), 0);
         check($sformatf("rst finished inst%0d", i), longint'(fin[i]), 0);
         check($sformatf("rst pass inst%0d", i), longint'(pas[i]), 0);
      end
      rst_n = '1;
      @(negedge clk);
      for (int i = 0; i < NI; i++)
         check($sformatf("ready_first_clock inst%0d", i), longint'(vec_ready[i]), 1);

      // All-correct truth table.
      send(0, 0, 0, 0, 0, 0, acc);
      send(0, 0, 1, 1, 0, 0, acc);
      send(0, 1, 0, 1, 0, 0, acc);
      send(0, 1, 1, 1, 0, 0, acc);
      vec_eof[0] = 1'b1;
      wait_fin(0);
      check("t1 vector_count", longint'(vcnt[0]), 4);
      check("t1 error_count", longint'(ecnt[0]), 0);
      check("t1 pass", longint'(pas[0]), 1);
      check("t1 chk_pulses", longint'(chk_seen[0]), 4);
      check("t1 done ready", longint'(vec_ready[0]), 0);

      // One wrong expectation first, then a good one.
      do_reset(0);
      send(0, 0, 0, 1, 1, 0, acc);
      send(0, 1, 1, 1, 0, 0, acc);
      vec_eof[0] = 1'b1;
      wait_fin(0);
      check("t2 vector_count", longint'(vcnt[0]), 2);
      check("t2 error_count", longint'(ecnt[0]), 1);
      check("t2 pass", longint'(pas[0]), 0);
`ifdef OR2_VECTOR_CHECKER_FIRST_FAIL_EN
      check("t2 ff_valid", longint'(ff_v[0]), 1);
      check("t2 ff_index", longint'(ff_idx[0]), 0);
      check("t2 ff_a", longint'(ff_a[0]), 0);
      check("t2 ff_b", longint'(ff_b[0]), 0);
      check("t2 ff_y", longint'(ff_y[0]), 0);
`endif

      // Valid and eof together: the vector wins, DONE follows.
      do_reset(0);
      vec_eof[0] = 1'b1;
      send(0, 1, 0, 1, 0, 0, acc);
      wait_fin(0);
      check("t4 vector_count", longint'(vcnt[0]), 1);
      check("t4 pass", longint'(pas[0]), 1);
      check("t4 chk_pulses", longint'(chk_seen[0]), 1);

      // Asynchronous reset during SETTLE.
      do_reset(0);
      send(0, 1, 1, 1, 0, 0, acc);
      #2;
      rst_n[0] = 1'b0;
      void'(exp_q[0].pop_back());
      void'(acc_q[0].pop_back());
      #1;
      check("t5 async a", longint'(a_o[0]), 0);
      check("t5 async b", longint'(b_o[0]), 0);
      check("t5 async vec_ready", longint'(vec_ready[0]), 0);
      @(negedge clk);
      rst_n[0] = 1'b1;
      @(negedge clk);
      check("t5 ready_after_release", longint'(vec_ready[0]), 1);
      repeat (4) @(negedge clk);
      check("t5 no chk", longint'(chk_seen[0]), 0);
      check("t5 vector_count", longint'(vcnt[0]), 0);

      // Held valid, settle 3: one accept every 5 cycles.
      prev = -1;
      for (int k = 0; k < 4; k++) begin
         send(1, k[0], k[1], k[0] | k[1], 0, (k < 3), acc);
         if (prev >= 0) check($sformatf("t3 accept_gap%0d", k), longint'(acc - prev), 5);
         prev = acc;
      end
      vec_eof[1] = 1'b1;
      wait_fin(1);
      check("t3 chk_pulses", longint'(chk_seen[1]), 4);
      check("t3 vector_count", longint'(vcnt[1]), 4);
      check("t3 pass", longint'(pas[1]), 1);

      // 2-bit counters, five wrong expectations.
      send(2, 0, 0, 1, 1, 0, acc);
      send(2, 0, 1, 0, 1, 0, acc);
      send(2, 1, 0, 0, 1, 0, acc);
      send(2, 1, 1, 0, 1, 0, acc);
      send(2, 0, 0, 1, 1, 0, acc);
      vec_eof[2] = 1'b1;
      wait_fin(2);
      check("t6 vector_count sat", longint'(vcnt[2]), 3);
      check("t6 error_count sat", longint'(ecnt[2]), 3);
      check("t6 pass", longint'(pas[2]), 0);
      check("t6 chk_pulses", longint'(chk_seen[2]), 5);

      for (int i = 0; i < NI; i++)
         check($sformatf("scoreboard_drained inst%0d", i), longint'(exp_q[i].size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/or2_vector_checker.md
Name: or2_vector_checker

Overview:
Hardware stimulus/checker stage that sits directly upstream and downstream of a 2-input OR stage (or2_gate / or2_dataflow / or2_behavioral).
- Accepts test vectors {a, b, y_expected} over a valid/ready handshake and drives a/b into the OR stage.
- Waits a settle interval, samples the returned y and compares it against the expected value.
- Keeps vector and error counts. A vector source asserts vec_eof to end the run, and the block then reports pass/fail.

Parameters:
SETTLE_CYCLES, 1, cycles between driving a/b and sampling y; 0 is treated as 1
CNT_WIDTH, 32, width of vector_count and error_count

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
vec_valid  input  1  vector present on vec_a/vec_b/vec_yexp
vec_ready  output  1  checker can accept a vector
vec_a  input  1  stimulus a
vec_b  input  1  stimulus b
vec_yexp  input  1  expected y
vec_eof  input  1  level; no more vectors
a  output  1  drive to OR stage input a
b  output  1  drive to OR stage input b
y  input  1  OR stage output
chk_pulse  output  1  one-cycle pulse, a vector was checked
err_pulse  output  1  one-cycle pulse, checked vector mismatched
vector_count  output  CNT_WIDTH  vectors checked
error_count  output  CNT_WIDTH  mismatches
finished  output  1  run complete
pass  output  1  finished and error_count==0

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low. All state is in flops cleared by rst_n.
- Reset values: state=IDLE; a=0, b=0, vec_ready=0, chk_pulse=0, err_pulse=0, vector_count=0, error_count=0, finished=0, pass=0. All outputs are registered.
- First clock after rst_n deasserts: vec_ready=1.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE (vec_ready=1):
  - vec_valid=1: accept the vector. Next edge: a<=vec_a, b<=vec_b, yexp_r<=vec_yexp, settle_cnt<=max(SETTLE_CYCLES,1)-1, vec_ready<=0, go to SETTLE.
  - vec_valid=0 and vec_eof=1: go to DONE.
  - vec_valid and vec_eof both 1: valid wins. The vector is accepted and checked; eof is re-sampled in the next IDLE.
- SETTLE: if settle_cnt==0, go to CHECK; else decrement. a/b are held.
- CHECK:
  - Sample y and compute mismatch = (y !== yexp_r). In simulation X/Z counts as a mismatch; the synthesized form is inequality.
  - Increment vector_count; increment error_count if mismatch. Both counters saturate at all-ones.
  - Next cycle: chk_pulse=1, err_pulse=mismatch, vec_ready=1, return to IDLE.
- Timing:
  - Accept edge to chk_pulse high = SETTLE_CYCLES+1 cycles.
  - Back-to-back throughput = one vector per SETTLE_CYCLES+2 cycles.
  - vec_ready deasserts the cycle after accept; no vector is ever dropped or duplicated.
- DONE:
  - finished=1, pass=(error_count==0), vec_ready=0. a/b hold their last values.
  - Sticky until reset; vec_valid is ignored.
- Reset mid-operation: any state aborts immediately. No chk_pulse is issued and the partial vector is not counted.
- Zero vectors then eof: DONE with vector_count=0 and pass=1.

Optional Feature:
OR2_VECTOR_CHECKER_FIRST_FAIL_EN
- Defined: adds outputs first_fail_valid(1), first_fail_index(CNT_WIDTH), first_fail_a(1), first_fail_b(1), first_fail_y(1), all reset to 0.
  - They capture vector_count (pre-increment, i.e. 0-based index), a, b and y on the first mismatch.
  - They hold until reset; later failures do not overwrite them.
- Undefined: these ports and their flops do not exist; all other behaviour is identical.

Decomposition:
- Shared header or2_vector_checker.vh holds:
  - state encoding localparams IDLE=2'd0, SETTLE=2'd1, CHECK=2'd2, DONE=2'd3;
  - default SETTLE_CYCLES;
  - the default for OR2_VECTOR_CHECKER_FIRST_FAIL_EN (commented out).
- One sub-module: sat_counter (parameter WIDTH; ports clk, rst_n, inc, count). It is instantiated for vector_count and error_count.

Test Plan:
- SETTLE_CYCLES=1, or2_behavioral in loop, vectors 00/0, 01/1, 10/1, 11/1, then eof -> chk_pulse 2 cycles after each accept; vector_count=4, error_count=0, finished=1, pass=1.
- Vectors 00/1, 11/1 -> err_pulse once on the first check; error_count=1, pass=0. With FIRST_FAIL_EN: first_fail_index=0, a=0, b=0, y=0.
- vec_valid held high over 4 vectors, SETTLE_CYCLES=3 -> vec_ready high 1 cycle in every 5; exactly 4 chk_pulses; vector_count=4.
- vec_valid=1 and vec_eof=1 in the same cycle with vector 10/1 -> vector checked (vector_count=1), then DONE on the next IDLE.
- rst_n pulled low during SETTLE -> outputs return to reset values immediately (asynchronous); no chk_pulse; vec_ready=1 one clock after release.
- CNT_WIDTH=2, 5 vectors all with wrong yexp -> error_count and vector_count saturate at 3; pass=0 after eof.
